reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Issue-side controller for the 32-entry register file.
- Tracks outstanding writes per destination register and holds the issue stage while a source or destination has an unresolved write.
- Sits between decode/issue and the register file's read ports. Writebacks from the write-back stage retire pending entries.
- Register 0 is hardwired zero: never tracked, never stalls.

Parameters:
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register index width.
- MAX_PEND, 3, maximum in-flight writes per register; sets counter width to 2 bits.
- MAX_OUTSTANDING, 8, global limit on total in-flight writes.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs  in  ADDR_W  first source register.
- issue_rt  in  ADDR_W  second source register.
- issue_uses_rt  in  1  rt is a true source (0 for immediate forms).
- issue_writes  in  1  instruction writes a register.
- issue_dst  in  ADDR_W  destination (rd or rt, already muxed by decode).
- issue_ready  out  1  instruction accepted this cycle when issue_valid is also high.
- wb_valid  in  1  write-back stage commits a register write this cycle.
- wb_dst  in  ADDR_W  register being written back.
- busy_vec  out  NUM_REGS  bit i = register i has at least one pending write; bit 0 always 0.
- outstanding  out  4  total pending writes, 0..MAX_OUTSTANDING.
- err_underflow  out  1  sticky; set on writeback to a register with zero pending.

Behaviour:
- Reset (asynchronous, reset_n low):
  - all per-register counters = 0; outstanding = 0; err_underflow = 0.
  - Therefore busy_vec = 0 and issue_ready = 1.
- Hazard terms (combinational, same cycle):
  - raw_rs = pend[rs] != 0 and rs != 0.
  - raw_rt = issue_uses_rt and pend[rt] != 0 and rt != 0.
  - dst_full = issue_writes and dst != 0 and pend[dst] == MAX_PEND.
  - glob_full = issue_writes and outstanding == MAX_OUTSTANDING.
- issue_ready = not (raw_rs or raw_rt or dst_full or glob_full).
  - issue_ready does not depend on issue_valid, so there is no combinational loop.
- Accept = issue_valid and issue_ready. On accept with issue_writes and dst != 0: pend[dst] increments and outstanding increments at the next rising edge.
- Retire = wb_valid and wb_dst != 0:
  - pend[wb_dst] decrements; outstanding decrements.
  - If pend[wb_dst] == 0, there is no change and err_underflow sets (held until reset).
- Simultaneous accept and retire:
  - Same register: pend unchanged, outstanding unchanged.
  - Different registers: each counter updates independently; outstanding unchanged.
- Retire when outstanding == MAX_OUTSTANDING and accept in the same cycle: glob_full still blocks the accept (no lookahead on the global count).
- Writes to register 0 on either side are ignored entirely.
- Latency: a stall clears in the cycle after the retiring writeback, unless WB_BYPASS_EN is defined.
- Reset asserted mid-operation discards all pending state. The bench flushes the pipeline alongside it.

Optional Feature:
- Macro: REG_SCOREBOARD_WB_BYPASS_EN.
- Defined: a source hazard is suppressed in the same cycle as a retire when wb_dst equals that source and its pend == 1. This is legal because the register file writes on the falling edge, before the next rising-edge read.
- Not defined: the hazard holds for that cycle; issue proceeds one cycle later.
- Destination and global checks are never bypassed.

Decomposition:
- Shared package/header holds:
  - REG_ADDR_W = 5, NUM_REGS = 32, ZERO_REG = 0.
  - Pending-counter width.
  - Control-bit indices for issue_writes and the destination select, consistent with the existing control word definitions.
- One natural sub-module: reg_pend_counter, a 2-bit saturating up/down counter.
  - Inputs: inc, dec. Outputs: count, nonzero, full, underflow.
  - Instantiated for registers 1..NUM_REGS-1.

Test Plan:
1. Reset, then issue dst=5 (writes=1), then next cycle issue rs=5 -> issue_ready=0, busy_vec[5]=1, outstanding=1. Then wb_dst=5 -> next cycle issue_ready=1, busy_vec[5]=0.
2. Issue dst=0, then rs=0 -> never stalls; busy_vec=0; outstanding stays 0.
3. Three issues to dst=7 -> pend=3; fourth issue to dst=7 gets issue_ready=0. Same-cycle issue dst=7 plus wb_dst=7 after one retire -> pend stays 2.
4. Eight writes to distinct regs 1..8 -> outstanding=8; ninth (dst=9) gets issue_ready=0 until any retire.
5. wb_valid with wb_dst=12 while pend[12]=0 -> err_underflow=1 and stays 1. Then reset_n low mid-stall -> all outputs return to reset values immediately.
6. Pending write on rs=3, pend=1, wb_dst=3 in the same cycle -> issue_ready=1 with REG_SCOREBOARD_WB_BYPASS_EN, 0 without it.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared widths, limits and types for the register scoreboard.
// Optional macro used by the top: REG_SCOREBOARD_WB_BYPASS_EN.
package reg_scoreboard_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int NUM_REGS        = 32;
    localparam int PEND_W          = 2;
    localparam int OUT_W           = 4;
    localparam int MAX_OUTSTANDING = 8;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
    localparam logic [PEND_W-1:0]     MAX_PEND = 2'd3;
    localparam logic [PEND_W-1:0]     PEND_ONE = 2'd1;
    localparam logic [OUT_W-1:0]      OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

    // Bit positions inside the decoder's control word.
    localparam int CTRL_WRITES_BIT  = 0;
    localparam int CTRL_DST_SEL_BIT = 1;

    typedef enum logic {
        DST_RD = 1'b0,
        DST_RT = 1'b1
    } dst_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rt;
        logic                  writes;
        logic [REG_ADDR_W-1:0] dst;
    } issue_req_t;

    function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] idx);
        return idx != ZERO_REG;
    endfunction

endpackage

// File: rtl/reg_pend_counter.sv
// Per-register pending-write counter: saturating 2-bit up/down count.
// Simultaneous inc and dec cancel; dec at zero is reported, not applied.
module reg_pend_counter
    import reg_scoreboard_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              nonzero,
    output logic              full,
    output logic              underflow
);

    assign nonzero   = count != '0;
    assign full      = count == MAX_PEND;
    assign underflow = dec && !inc && !nonzero;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + PEND_W'(1);
        end else if (dec && !inc && nonzero) begin
            count <= count - PEND_W'(1);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side scoreboard: tracks in-flight register writes and stalls issue on hazards.
// Define REG_SCOREBOARD_WB_BYPASS_EN to clear a source hazard in the retiring cycle.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs,
    input  logic [REG_ADDR_W-1:0] issue_rt,
    input  logic                  issue_uses_rt,
    input  logic                  issue_writes,
    input  logic [REG_ADDR_W-1:0] issue_dst,
    output logic                  issue_ready,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dst,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic [OUT_W-1:0]      outstanding,
    output logic                  err_underflow
);

    issue_req_t req;
    assign req = '{valid:   issue_valid,
                   rs:      issue_rs,
                   rt:      issue_rt,
                   uses_rt: issue_uses_rt,
                   writes:  issue_writes,
                   dst:     issue_dst};

    logic [PEND_W-1:0]   pend [NUM_REGS];
    logic [NUM_REGS-1:0] nonzero_vec;
    logic [NUM_REGS-1:0] full_vec;
    logic [NUM_REGS-1:0] underflow_vec;

    logic retire;
    logic accept_write;
    logic raw_rs;
    logic raw_rt;
    logic dst_full;
    logic glob_full;
    logic out_inc;
    logic out_dec;

    assign retire = wb_valid && is_real_reg(wb_dst);

    // Register 0 has no counter; its slot is tied off so lookups stay uniform.
    assign pend[0]          = '0;
    assign nonzero_vec[0]   = 1'b0;
    assign full_vec[0]      = 1'b0;
    assign underflow_vec[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_pend
        reg_pend_counter u_cnt (
            .clock     (clock),
            .reset_n   (reset_n),
            .inc       (accept_write && (req.dst == REG_ADDR_W'(i))),
            .dec       (retire && (wb_dst == REG_ADDR_W'(i))),
            .count     (pend[i]),
            .nonzero   (nonzero_vec[i]),
            .full      (full_vec[i]),
            .underflow (underflow_vec[i])
        );
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        raw_rs    = 1'b0;
        raw_rt    = 1'b0;
        dst_full  = 1'b0;
        glob_full = 1'b0;

        raw_rs = is_real_reg(req.rs) && nonzero_vec[req.rs];
        raw_rt = req.uses_rt && is_real_reg(req.rt) && nonzero_vec[req.rt];
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
        // The register file writes on the falling edge, so a last pending
        // write retiring now is visible to this cycle's read.
        if (retire && (wb_dst == req.rs) && (pend[req.rs] == PEND_ONE))
            raw_rs = 1'b0;
        if (retire && (wb_dst == req.rt) && (pend[req.rt] == PEND_ONE))
            raw_rt = 1'b0;
`endif
        dst_full  = req.writes && is_real_reg(req.dst) && full_vec[req.dst];
        glob_full = req.writes && (outstanding == OUT_MAX);
    end

    assign issue_ready  = !(raw_rs || raw_rt || dst_full || glob_full);
    assign accept_write = req.valid && issue_ready && req.writes && is_real_reg(req.dst);

    // A retire only removes a write if one is pending, or if the same register
    // is being accepted this cycle (the pair cancels inside the counter).
    assign out_inc = accept_write;
    assign out_dec = retire && ((pend[wb_dst] != '0) ||
                                (accept_write && (req.dst == wb_dst)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (out_inc && !out_dec)
                outstanding <= outstanding + OUT_W'(1);
            else if (out_dec && !out_inc)
                outstanding <= outstanding - OUT_W'(1);
            if (|underflow_vec)
                err_underflow <= 1'b1;
        end
    end

    assign busy_vec = nonzero_vec;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
// Expectations for the same-cycle retire case follow REG_SCOREBOARD_WB_BYPASS_EN.
module tb_reg_scoreboard;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_uses_rt;
    logic        issue_writes;
    logic [4:0]  issue_dst;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic [31:0] busy_vec;
    logic [3:0]  outstanding;
    logic        err_underflow;

    int total = 0;
    int bad   = 0;

    reg_scoreboard dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .issue_valid   (issue_valid),
        .issue_rs      (issue_rs),
        .issue_rt      (issue_rt),
        .issue_uses_rt (issue_uses_rt),
        .issue_writes  (issue_writes),
        .issue_dst     (issue_dst),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_dst        (wb_dst),
        .busy_vec      (busy_vec),
        .outstanding   (outstanding),
        .err_underflow (err_underflow)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_uses_rt = 0;
        issue_writes = 0; issue_dst = 0; wb_valid = 0; wb_dst = 0;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic writes, input logic [4:0] dst);
        issue_valid = 1; issue_rs = rs; issue_rt = rt; issue_uses_rt = uses_rt;
        issue_writes = writes; issue_dst = dst;
        #1;
    endtask

    task automatic wb(input logic [4:0] dst);
        wb_valid = 1; wb_dst = dst;
        #1;
    endtask

    task automatic test_reset;
        idle();
        reset_n = 0;
        #12;
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", issue_ready); end
        total++;
        if (busy_vec !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h want=0", busy_vec); end
        total++;
        if (outstanding !== 4'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding); end
        total++;
        if (err_underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err_underflow); end
        @(negedge clock);
        reset_n = 1;
        tick();
    endtask

    task automatic test_basic_raw;
        issue(0, 0, 0, 1, 5);
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL raw_first_ready got=%0b want=1", issue_ready); end
        tick();
        issue(5, 0, 0, 0, 0);
        total++;
        if (issue_ready !== 1'b0) begin bad++; $display("FAIL raw_stall got=%0b want=0", issue_ready); end
        total++;
        if (busy_vec !== 32'h0000_0020) begin bad++; $display("FAIL raw_busy got=%h want=00000020", busy_vec); end
        total++;
        if (outstanding !== 4'd1) begin bad++; $display("FAIL raw_outstanding got=%0d want=1", outstanding); end
        issue_valid = 0;
        wb(5);
        tick();
        wb_valid = 0;
        issue(5, 0, 0, 0, 0);
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL raw_release got=%0b want=1", issue_ready); end
        total++;
        if (busy_vec !== 32'h0) begin bad++; $display("FAIL raw_busy_clear got=%h want=0", busy_vec); end
        total++;
        if (outstanding !== 4'd0) begin bad++; $display("FAIL raw_out_clear got=%0d want=0", outstanding); end
        idle();
    endtask

    task automatic test_reg_zero;
        issue(0, 0, 1, 1, 0);
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL zero_dst_ready got=%0b want=1", issue_ready); end
        tick();
        wb(0);
        issue(0, 0, 1, 0, 0);
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL zero_src_ready got=%0b want=1", issue_ready); end
        tick();
        idle();
        #1;
        total++;
        if (busy_vec !== 32'h0) begin bad++; $display("FAIL zero_busy got=%h want=0", busy_vec); end
        total++;
        if (outstanding !== 4'd0) begin bad++; $display("FAIL zero_outstanding got=%0d want=0", outstanding); end
        total++;
        if (err_underflow !== 1'b0) begin bad++; $display("FAIL zero_wb_err got=%0b want=0", err_underflow); end
    endtask

    task automatic test_dst_full;
        for (int k = 0; k < 3; k++) begin
            issue(0, 0, 0, 1, 7);
            total++;
            if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_fill%0d got=%0b want=1", k, issue_ready); end
            tick();
        end
        issue(0, 0, 0, 1, 7);
        total++;
        if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_block got=%0b want=0", issue_ready); end
        total++;
        if (outstanding !== 4'd3) begin bad++; $display("FAIL full_out3 got=%0d want=3", outstanding); end
        tick();
        total++;
        if (outstanding !== 4'd3) begin bad++; $display("FAIL full_not_taken got=%0d want=3", outstanding); end
        issue_valid = 0;
        wb(7);
        tick();
        wb_valid = 0;
        total++;
        if (outstanding !== 4'd2) begin bad++; $display("FAIL full_retire got=%0d want=2", outstanding); end
        issue(0, 0, 0, 1, 7);
        wb(7);
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_same_ready got=%0b want=1", issue_ready); end
        tick();
        idle();
        #1;
        total++;
        if (outstanding !== 4'd2) begin bad++; $display("FAIL full_same_out got=%0d want=2", outstanding); end
        total++;
        if (busy_vec !== 32'h0000_0080) begin bad++; $display("FAIL full_same_busy got=%h want=00000080", busy_vec); end
        // Two retires left: pend 2 -> 0.
        issue(0, 0, 0, 1, 7);
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_pend2_ready got=%0b want=1", issue_ready); end
        issue_valid = 0;
        wb(7); tick(); tick();
        wb_valid = 0;
        #1;
        total++;
        if (busy_vec !== 32'h0 || outstanding !== 4'd0) begin
            bad++; $display("FAIL full_drain busy=%h out=%0d want busy=0 out=0", busy_vec, outstanding);
        end
    endtask

    task automatic test_glob_full;
        for (int r = 1; r <= 8; r++) begin
            issue(0, 0, 0, 1, 5'(r));
            tick();
        end
        idle();
        #1;
        total++;
        if (outstanding !== 4'd8) begin bad++; $display("FAIL glob_out8 got=%0d want=8", outstanding); end
        total++;
        if (busy_vec !== 32'h0000_01FE) begin bad++; $display("FAIL glob_busy got=%h want=000001fe", busy_vec); end
        issue(0, 0, 0, 1, 9);
        total++;
        if (issue_ready !== 1'b0) begin bad++; $display("FAIL glob_block got=%0b want=0", issue_ready); end
        issue(10, 11, 1, 0, 0);
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL glob_nowrite_ready got=%0b want=1", issue_ready); end
        issue(0, 0, 0, 1, 9);
        wb(1);
        total++;
        if (issue_ready !== 1'b0) begin bad++; $display("FAIL glob_no_lookahead got=%0b want=0", issue_ready); end
        tick();
        wb_valid = 0;
        #1;
        total++;
        if (outstanding !== 4'd7) begin bad++; $display("FAIL glob_out7 got=%0d want=7", outstanding); end
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL glob_release got=%0b want=1", issue_ready); end
        tick();
        issue_valid = 0;
        #1;
        total++;
        if (outstanding !== 4'd8) begin bad++; $display("FAIL glob_refill got=%0d want=8", outstanding); end
        for (int r = 2; r <= 9; r++) begin
            wb(5'(r));
            tick();
        end
        idle();
        #1;
        total++;
        if (outstanding !== 4'd0 || busy_vec !== 32'h0) begin
            bad++; $display("FAIL glob_drain out=%0d busy=%h want out=0 busy=0", outstanding, busy_vec);
        end
    endtask

    task automatic test_underflow_and_reset;
        wb(12);
        tick();
        wb_valid = 0;
        #1;
        total++;
        if (err_underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%0b want=1", err_underflow); end
        total++;
        if (outstanding !== 4'd0) begin bad++; $display("FAIL uf_out got=%0d want=0", outstanding); end
        tick(); tick();
        total++;
        if (err_underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%0b want=1", err_underflow); end
        issue(0, 0, 0, 1, 4);
        tick();
        issue(4, 0, 0, 0, 0);
        total++;
        if (issue_ready !== 1'b0) begin bad++; $display("FAIL uf_stall got=%0b want=0", issue_ready); end
        #2;
        reset_n = 0;
        #1;
        total++;
        if (issue_ready !== 1'b1 || busy_vec !== 32'h0 || outstanding !== 4'd0 || err_underflow !== 1'b0) begin
            bad++;
            $display("FAIL midreset ready=%0b busy=%h out=%0d err=%0b want 1/0/0/0",
                     issue_ready, busy_vec, outstanding, err_underflow);
        end
        idle();
        @(negedge clock);
        reset_n = 1;
        tick();
    endtask

    task automatic test_bypass;
        logic exp_ready;
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
        exp_ready = 1'b1;
`else
        exp_ready = 1'b0;
`endif
        issue(0, 0, 0, 1, 3);
        tick();
        issue(0, 3, 0, 0, 0);
        total++;
        if (issue_ready !== 1'b1) begin bad++; $display("FAIL byp_rt_unused got=%0b want=1", issue_ready); end
        issue(0, 3, 1, 0, 0);
        total++;
        if (issue_ready !== 1'b0) begin bad++; $display("FAIL byp_rt_stall got=%0b want=0", issue_ready); end
        wb(3);
        total++;
        if (issue_ready !== exp_ready) begin bad++; $display("FAIL byp_rt_same got=%0b want=%0b", issue_ready, exp_ready); end
        issue(3, 0, 0, 0, 0);
        total++;
        if (issue_ready !== exp_ready) begin bad++; $display("FAIL byp_rs_same got=%0b want=%0b", issue_ready, exp_ready); end
        issue(3, 0, 0, 1, 3);
        tick();
        idle();
        #1;
        // The bypassed issue also wrote r3; without bypass it stalled and wrote nothing.
        total++;
        if (outstanding !== 4'(exp_ready)) begin
            bad++; $display("FAIL byp_after_out got=%0d want=%0d", outstanding, exp_ready);
        end
        issue(3, 0, 0, 0, 0);
        total++;
        if (issue_ready !== !exp_ready) begin bad++; $display("FAIL byp_after_ready got=%0b want=%0b", issue_ready, !exp_ready); end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic_raw();
        test_reg_zero();
        test_dst_full();
        test_glob_full();
        test_underflow_and_reset();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
